// File: rtl/wb_stage_p_pkg.sv
// Shared constants for the write-back stage: data width, default result
// source indices and the RV32I load funct3 encodings.
package wb_stage_p_pkg;

  localparam int unsigned XLEN = 32;

  // Default source indices into the flattened src_data bus
  localparam int unsigned SRC_ALU   = 0;
  localparam int unsigned SRC_LOAD  = 1;
  localparam int unsigned SRC_PC4   = 2;
  localparam int unsigned SRC_IMM   = 3;
  localparam int unsigned SRC_AUIPC = 4;

  // Load funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/wb_stage_p_load_align.sv
// wb_load_align: combinational load-data aligner for RV32I loads.
// Ports:
//   raw    - raw memory read word
//   funct3 - load type
//   off    - byte offset of the load address
//   data   - aligned, sign/zero-extended load result (0 on error)
//   err    - misaligned offset or illegal funct3
module wb_load_align
  import wb_stage_p_pkg::F3_LB;
  import wb_stage_p_pkg::F3_LH;
  import wb_stage_p_pkg::F3_LW;
  import wb_stage_p_pkg::F3_LBU;
  import wb_stage_p_pkg::F3_LHU;
#(
  parameter int unsigned XLEN = wb_stage_p_pkg::XLEN
) (
  input  logic [XLEN-1:0] raw,
  input  logic [2:0]      funct3,
  input  logic [1:0]      off,
  output logic [XLEN-1:0] data,
  output logic            err
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte and half-word lanes
  always_comb begin
    byte_sel = raw[7:0];
    case (off)
      2'd0:    byte_sel = raw[7:0];
      2'd1:    byte_sel = raw[15:8];
      2'd2:    byte_sel = raw[23:16];
      default: byte_sel = raw[31:24];
    endcase
    half_sel = off[1] ? raw[31:16] : raw[15:0];
  end

  // Extension and error decode
  always_comb begin
    data = '0;
    err  = 1'b0;
    case (funct3)
      F3_LB:  data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU: data = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH: begin
        if (off[0]) err  = 1'b1;
        else        data = {{(XLEN-16){half_sel[15]}}, half_sel};
      end
      F3_LHU: begin
        if (off[0]) err  = 1'b1;
        else        data = {{(XLEN-16){1'b0}}, half_sel};
      end
      F3_LW: begin
        if (off != 2'd0) err  = 1'b1;
        else             data = raw;
      end
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_stage_p.sv
// wb_stage_p: write-back result select, load alignment and a one-entry
// valid/ready output register driving the register-file write port.
// Ports:
//   clk, rst_n              - clock, synchronous active-low reset
//   in_valid / in_ready     - upstream handshake (in_ready combinational)
//   src_data                - NUM_SRC flattened XLEN-bit result sources
//   wb_sel                  - source select (>= NUM_SRC selects zero)
//   ld_funct3, ld_addr_lo   - load type and byte offset for LOAD_SRC
//   reg_we, rd_addr         - instruction destination write intent
//   out_ready / out_valid   - downstream handshake
//   rf_we, rf_waddr, rf_wdata - register-file write port
//   wb_err                  - held transaction is a bad load
//   retire_cnt              - completed output handshakes (wraps)
module wb_stage_p #(
  parameter int unsigned XLEN     = wb_stage_p_pkg::XLEN,
  parameter int unsigned NUM_SRC  = 5,
  parameter int unsigned SEL_W    = 3,
  parameter int unsigned LOAD_SRC = wb_stage_p_pkg::SRC_LOAD,
  parameter int unsigned RA_W     = 5,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_SRC*XLEN-1:0] src_data,
  input  logic [SEL_W-1:0]        wb_sel,
  input  logic [2:0]              ld_funct3,
  input  logic [1:0]              ld_addr_lo,
  input  logic                    reg_we,
  input  logic [RA_W-1:0]         rd_addr,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic                    rf_we,
  output logic [RA_W-1:0]         rf_waddr,
  output logic [XLEN-1:0]         rf_wdata,
  output logic                    wb_err,
  output logic [CNT_W-1:0]        retire_cnt
);

  logic [XLEN-1:0] mux_data;
  logic [XLEN-1:0] load_raw;
  logic [XLEN-1:0] load_data;
  logic            load_err;
  logic [XLEN-1:0] nxt_data;
  logic            nxt_err;
  logic            nxt_we;
  logic            capture;
  logic            drain;

  logic            valid_q;
  logic            we_q;
  logic            err_q;
  logic [RA_W-1:0] waddr_q;
  logic [XLEN-1:0] wdata_q;
  logic [CNT_W-1:0] cnt_q;

  assign load_raw = src_data[LOAD_SRC*XLEN +: XLEN];

  wb_load_align #(
    .XLEN (XLEN)
  ) u_align (
    .raw    (load_raw),
    .funct3 (ld_funct3),
    .off    (ld_addr_lo),
    .data   (load_data),
    .err    (load_err)
  );

  // Source mux; out-of-range selects fall through to zero
  always_comb begin
    mux_data = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (wb_sel == SEL_W'(i)) mux_data = src_data[i*XLEN +: XLEN];
    end
  end

  // Only the load source is aligned and can raise an error
  always_comb begin
    nxt_data = mux_data;
    nxt_err  = 1'b0;
    if (wb_sel == SEL_W'(LOAD_SRC)) begin
      nxt_data = load_data;
      nxt_err  = load_err;
    end
    nxt_we = reg_we && (rd_addr != '0) && !nxt_err;
  end

  assign in_ready = !valid_q || out_ready;
  assign capture  = in_valid && in_ready;
  assign drain    = valid_q && out_ready;

  // One-entry pipeline register and retire counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      if (capture) begin
        valid_q <= 1'b1;
        we_q    <= nxt_we;
        err_q   <= nxt_err;
        waddr_q <= rd_addr;
        wdata_q <= nxt_data;
      end else if (drain) begin
        valid_q <= 1'b0;
      end
      if (drain) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign out_valid  = valid_q;
  assign rf_we      = valid_q && we_q;
  assign rf_waddr   = waddr_q;
  assign rf_wdata   = wdata_q;
  assign wb_err     = valid_q && err_q;
  assign retire_cnt = cnt_q;

endmodule

// File: tb/tb_wb_stage_p.sv
module tb_wb_stage_p;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned NUM_SRC = 5;
  localparam int unsigned SEL_W   = 3;
  localparam int unsigned RA_W    = 5;
  localparam int unsigned CNT_W   = 32;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    in_valid;
  logic                    in_ready;
  logic [NUM_SRC*XLEN-1:0] src_data;
  logic [SEL_W-1:0]        wb_sel;
  logic [2:0]              ld_funct3;
  logic [1:0]              ld_addr_lo;
  logic                    reg_we;
  logic [RA_W-1:0]         rd_addr;
  logic                    out_ready;
  logic                    out_valid;
  logic                    rf_we;
  logic [RA_W-1:0]         rf_waddr;
  logic [XLEN-1:0]         rf_wdata;
  logic                    wb_err;
  logic [CNT_W-1:0]        retire_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_cnt = 0;

  always #5 clk = ~clk;

  wb_stage_p #(
    .XLEN(XLEN), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .LOAD_SRC(1),
    .RA_W(RA_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .src_data(src_data), .wb_sel(wb_sel), .ld_funct3(ld_funct3),
    .ld_addr_lo(ld_addr_lo), .reg_we(reg_we), .rd_addr(rd_addr),
    .out_ready(out_ready), .out_valid(out_valid), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .wb_err(wb_err),
    .retire_cnt(retire_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Non-selected sources carry distinct nonzero filler
  task automatic drive(input logic [2:0] sel, input logic [31:0] w, input logic [2:0] f3,
                       input logic [1:0] off, input logic [4:0] rd, input logic we);
    for (int i = 0; i < int'(NUM_SRC); i++) src_data[i*32 +: 32] = 32'hA5A5_0000 | 32'(i);
    if (int'(sel) < int'(NUM_SRC)) src_data[int'(sel)*32 +: 32] = w;
    wb_sel     = sel;
    ld_funct3  = f3;
    ld_addr_lo = off;
    rd_addr    = rd;
    reg_we     = we;
    in_valid   = 1'b1;
  endtask

  // Single transaction with out_ready high: check held output, then retirement
  task automatic one(input string tag, input logic [2:0] sel, input logic [31:0] w,
                     input logic [2:0] f3, input logic [1:0] off, input logic [4:0] rd,
                     input logic we, input logic [31:0] e_data, input logic e_we,
                     input logic e_err);
    drive(sel, w, f3, off, rd, we);
    tick();
    in_valid = 1'b0;
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
    check({tag, ".we"},    32'(rf_we), 32'(e_we));
    check({tag, ".addr"},  32'(rf_waddr), 32'(rd));
    check({tag, ".data"},  rf_wdata, e_data);
    check({tag, ".err"},   32'(wb_err), 32'(e_err));
    tick();
    exp_cnt++;
    check({tag, ".cnt"},   retire_cnt, exp_cnt);
    check({tag, ".drain"}, 32'(out_valid), 32'd0);
  endtask

  localparam logic [31:0] W = 32'h80FF_7F01;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    src_data = '0; wb_sel = '0; ld_funct3 = '0; ld_addr_lo = '0;
    reg_we = 1'b0; rd_addr = '0;
    tick(); tick();
    rst_n = 1'b1;
    check("rst.valid", 32'(out_valid), 32'd0);
    check("rst.we",    32'(rf_we), 32'd0);
    check("rst.addr",  32'(rf_waddr), 32'd0);
    check("rst.data",  rf_wdata, 32'd0);
    check("rst.err",   32'(wb_err), 32'd0);
    check("rst.cnt",   retire_cnt, 32'd0);
    check("rst.rdy",   32'(in_ready), 32'd1);

    one("alu",  3'd0, 32'h1234_5678, 3'b000, 2'd0, 5'd5, 1'b1, 32'h1234_5678, 1'b1, 1'b0);
    one("lb3",  3'd1, W, 3'b000, 2'd3, 5'd6, 1'b1, 32'hFFFF_FF80, 1'b1, 1'b0);
    one("lbu3", 3'd1, W, 3'b100, 2'd3, 5'd7, 1'b1, 32'h0000_0080, 1'b1, 1'b0);
    one("lb1",  3'd1, W, 3'b000, 2'd1, 5'd7, 1'b1, 32'h0000_007F, 1'b1, 1'b0);
    one("lh2",  3'd1, W, 3'b001, 2'd2, 5'd8, 1'b1, 32'hFFFF_80FF, 1'b1, 1'b0);
    one("lhu0", 3'd1, W, 3'b101, 2'd0, 5'd9, 1'b1, 32'h0000_7F01, 1'b1, 1'b0);
    one("lw0",  3'd1, W, 3'b010, 2'd0, 5'd10, 1'b1, 32'h80FF_7F01, 1'b1, 1'b0);
    one("lw2",  3'd1, W, 3'b010, 2'd2, 5'd11, 1'b1, 32'h0, 1'b0, 1'b1);
    one("lh1",  3'd1, W, 3'b001, 2'd1, 5'd11, 1'b1, 32'h0, 1'b0, 1'b1);
    one("f011", 3'd1, W, 3'b011, 2'd0, 5'd12, 1'b1, 32'h0, 1'b0, 1'b1);
    one("f011alu", 3'd0, 32'hCAFE_0001, 3'b011, 2'd1, 5'd12, 1'b1, 32'hCAFE_0001, 1'b1, 1'b0);
    one("rd0",  3'd0, 32'hDEAD_BEEF, 3'b000, 2'd0, 5'd0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    one("nowe", 3'd3, 32'h0000_1111, 3'b000, 2'd0, 5'd4, 1'b0, 32'h0000_1111, 1'b0, 1'b0);
    one("pc4",  3'd2, 32'h0000_2004, 3'b000, 2'd0, 5'd1, 1'b1, 32'h0000_2004, 1'b1, 1'b0);
    one("sel7", 3'd7, 32'h0, 3'b000, 2'd0, 5'd3, 1'b1, 32'h0, 1'b1, 1'b0);

    // Backpressure: A captured, stall two cycles with B pending, then drain A,B,C
    out_ready = 1'b0;
    drive(3'd0, 32'hAAAA_0001, 3'b000, 2'd0, 5'd1, 1'b1);
    tick();
    drive(3'd4, 32'hBBBB_0002, 3'b000, 2'd0, 5'd2, 1'b1);
    check("bp.rdy0",  32'(in_ready), 32'd0);
    check("bp.dataA", rf_wdata, 32'hAAAA_0001);
    for (int k = 0; k < 2; k++) begin
      tick();
      check("bp.hold.valid", 32'(out_valid), 32'd1);
      check("bp.hold.we",    32'(rf_we), 32'd1);
      check("bp.hold.rdy",   32'(in_ready), 32'd0);
      check("bp.hold.addr",  32'(rf_waddr), 32'd1);
      check("bp.hold.data",  rf_wdata, 32'hAAAA_0001);
      check("bp.hold.cnt",   retire_cnt, exp_cnt);
    end
    out_ready = 1'b1;
    #1;
    check("bp.rdy1", 32'(in_ready), 32'd1);
    tick();
    exp_cnt++;
    check("bp.dataB", rf_wdata, 32'hBBBB_0002);
    check("bp.addrB", 32'(rf_waddr), 32'd2);
    check("bp.cntA",  retire_cnt, exp_cnt);
    drive(3'd3, 32'hCCCC_0003, 3'b000, 2'd0, 5'd3, 1'b1);
    tick();
    in_valid = 1'b0;
    exp_cnt++;
    check("bp.dataC", rf_wdata, 32'hCCCC_0003);
    check("bp.cntB",  retire_cnt, exp_cnt);
    tick();
    exp_cnt++;
    check("bp.cntC",  retire_cnt, exp_cnt);
    check("bp.empty", 32'(out_valid), 32'd0);

    // Full-rate streaming with out_ready high
    for (int k = 0; k < 4; k++) begin
      drive(3'd0, 32'h5000_0000 + 32'(k), 3'b000, 2'd0, 5'(k + 1), 1'b1);
      #1;
      check("st.rdy", 32'(in_ready), 32'd1);
      tick();
      if (k > 0) exp_cnt++;
      check("st.data", rf_wdata, 32'h5000_0000 + 32'(k));
      check("st.cnt",  retire_cnt, exp_cnt);
    end
    in_valid = 1'b0;
    tick();
    exp_cnt++;
    check("st.cntend", retire_cnt, exp_cnt);

    // Reset while a transaction is stalled in the register
    out_ready = 1'b0;
    drive(3'd0, 32'h7777_7777, 3'b000, 2'd0, 5'd9, 1'b1);
    tick();
    in_valid = 1'b0;
    tick();
    check("rs.stall", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rs.valid", 32'(out_valid), 32'd0);
    check("rs.we",    32'(rf_we), 32'd0);
    check("rs.cnt",   retire_cnt, 32'd0);
    check("rs.data",  rf_wdata, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
